// File: rtl/route_demux_pkg.sv
// Shared definitions for the bit-serial NoC ingress demux: header geometry,
// next-hop fan-out and the steering FSM state type.
package route_demux_pkg;

  localparam int unsigned ROUTE_HOPW   = 2;
  localparam int unsigned ROUTE_LENW   = 8;
  localparam int unsigned ROUTE_HDRW   = ROUTE_HOPW + ROUTE_LENW;
  localparam int unsigned NEXTHOPWIDTH = 1 << ROUTE_HOPW;

  // Header field offsets (header arrives LSB first)
  localparam int unsigned HDR_HOP_LSB = 0;
  localparam int unsigned HDR_LEN_LSB = ROUTE_HOPW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_DRAIN,
    ST_ERRW
  } state_e;

  // Counter must hold both a full LEN value and the header/drain length.
  function automatic int unsigned cnt_width(input int unsigned lenw, input int unsigned hdrw);
    int unsigned hw;
    hw = $clog2(hdrw + 1);
    return (lenw > hw) ? lenw : hw;
  endfunction

endpackage

// File: rtl/route_delay_line.sv
// Serial delay line with synchronous clear; newest bit enters at the MSB,
// so taps_o[j] holds the j-th oldest stored bit and taps_o[0] is the tail.
module route_delay_line #(
  parameter int unsigned DEPTH = 9
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [DEPTH-1:0] taps_o
);

  logic [DEPTH-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      line_q <= '0;
    end else if (shift_i) begin
      line_q <= {bit_i, line_q[DEPTH-1:1]};
    end
  end

  assign taps_o = line_q;

endmodule

// File: rtl/route_demux.sv
// Ingress steering for one bit-serial NoC link: parses each packet header and
// forwards the whole packet, delayed by the header length, to one next-hop lane.
module route_demux
  import route_demux_pkg::*;
#(
  parameter int unsigned HOPW = ROUTE_HOPW,
  parameter int unsigned LENW = ROUTE_LENW,
  parameter int unsigned HDRW = HOPW + LENW,
  parameter int unsigned NH   = 1 << HOPW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic [NH-1:0] out_bit,
  output logic [NH-1:0] out_valid,
  output logic [NH-1:0] sel,
  output logic          busy,
  output logic          err
);

  localparam int unsigned CNTW = cnt_width(LENW, HDRW);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NH-1:0]   sel_q, sel_d;
  logic [NH-1:0]   obit_q, obit_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;

  logic            dl_clear, dl_shift, dl_bit;
  logic [HDRW-2:0] taps;
  logic [HDRW-1:0] hdr;
  logic [HOPW-1:0] hop;
  logic [LENW-1:0] len;

  // The line is one stage short of HDRW; the lane-steered output register
  // is the final stage, keeping out_bit registered at latency HDRW.
  route_delay_line #(
    .DEPTH(HDRW - 1)
  ) u_dl (
    .clk_i  (clk),
    .clear_i(rst | dl_clear),
    .shift_i(dl_shift),
    .bit_i  (dl_bit),
    .taps_o (taps)
  );

  // On the last header bit the line already holds bits 0..HDRW-2 in order.
  assign hdr = {in_bit, taps};
  assign hop = hdr[HDR_HOP_LSB +: HOPW];
  assign len = hdr[HOPW +: LENW];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    ovf_d    = ovf_q;
    dl_clear = 1'b0;
    dl_shift = 1'b0;
    dl_bit   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d  = ST_HDR;
          cnt_d    = CNTW'(1);
          dl_shift = 1'b1;
          dl_bit   = in_bit;
        end
      end
      ST_HDR: begin
        if (!in_valid) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          err_d    = 1'b1;
          dl_clear = 1'b1;
        end else begin
          dl_shift = 1'b1;
          dl_bit   = in_bit;
          if (cnt_q == CNTW'(HDRW - 1)) begin
            sel_d = NH'(1) << hop;
            if (len == '0) begin
              state_d = ST_DRAIN;
              cnt_d   = CNTW'(HDRW);
            end else begin
              state_d = ST_PAY;
              cnt_d   = CNTW'(len);
            end
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      ST_PAY: begin
        if (!in_valid) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          sel_d    = '0;
          err_d    = 1'b1;
          dl_clear = 1'b1;
        end else begin
          dl_shift = 1'b1;
          dl_bit   = in_bit;
          if (cnt_q == CNTW'(1)) begin
            state_d = ST_DRAIN;
            cnt_d   = CNTW'(HDRW);
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Shift zeros so over-long input bits never reach the tail.
        dl_shift = 1'b1;
        if (in_valid && !ovf_q) begin
          err_d = 1'b1;
          ovf_d = 1'b1;
        end
        if (cnt_q == CNTW'(1)) begin
          sel_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (ovf_q || in_valid) ? ST_ERRW : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_ERRW: begin
        if (!in_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    obit_d = sel_d & {NH{taps[0]}};
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      obit_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      obit_q  <= obit_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_bit   = obit_q;
  assign out_valid = sel_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_route_demux.sv
// Bench for route_demux: packets are scheduled on an absolute cycle timeline and
// the expected lane outputs are derived from packet-level timing rules.
module tb_route_demux;
  import route_demux_pkg::*;

  localparam int HDRW = ROUTE_HDRW;
  localparam int NH   = NEXTHOPWIDTH;
  localparam int MAXC = 4096;

  localparam int K_CLEAN = 0;
  localparam int K_TRUNC = 1;
  localparam int K_LONG  = 2;
  localparam int K_RST   = 3;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_bit;
  logic [NH-1:0] out_bit, out_valid, sel;
  logic          busy, err;

  bit          st_r [MAXC];
  bit          st_v [MAXC];
  bit          st_b [MAXC];
  bit [NH-1:0] ex_ov [MAXC];
  bit [NH-1:0] ex_ob [MAXC];
  bit          ex_busy [MAXC];
  bit          ex_err [MAXC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  route_demux #(
    .HOPW(ROUTE_HOPW),
    .LENW(ROUTE_LENW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .sel      (sel),
    .busy     (busy),
    .err      (err)
  );

  task automatic chk(input string tag, input int c, input logic [NH-1:0] got, input logic [NH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  // Schedule one packet starting at cycle s; nxt is the earliest legal next start.
  task automatic sched(input int s, input int h, input int len, input logic [255:0] pay,
                       input int kind, input int arg, output int nxt);
    logic [HDRW+255:0] stream;
    int total, nv, last, cut, bend;
    stream = {pay, ROUTE_LENW'(len), ROUTE_HOPW'(h)};
    total  = HDRW + len;
    last   = s + 2 * HDRW + len - 1;
    case (kind)
      K_TRUNC: begin nv = arg;         cut = s + arg; bend = s + arg;  nxt = s + arg + 1; end
      K_LONG:  begin nv = total + arg; cut = last;    bend = last + 1; nxt = last + 2;    end
      K_RST:   begin nv = arg + 1;     cut = s + arg; bend = s + arg;  nxt = s + arg + 1; end
      default: begin nv = total;       cut = last;    bend = last;     nxt = last + 1;    end
    endcase
    for (int k = 0; k < nv; k++) begin
      st_v[s + k] = 1'b1;
      st_b[s + k] = (k < total) ? stream[k] : 1'($urandom);
    end
    for (int c = s + HDRW; c <= ((cut < last) ? cut : last); c++) begin
      ex_ov[c] = NH'(1) << h;
      ex_ob[c] = NH'(stream[c - s - HDRW]) << h;
    end
    for (int c = s + 1; c <= bend; c++) ex_busy[c] = 1'b1;
    if (kind == K_TRUNC) ex_err[s + arg + 1] = 1'b1;
    if (kind == K_LONG)  ex_err[s + total + 1] = 1'b1;
    if (kind == K_RST)   st_r[s + arg] = 1'b1;
  endtask

  function automatic logic [255:0] rand_pay();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  initial begin
    int t, endc, len, h;
    st_r[0] = 1'b1;
    st_r[1] = 1'b1;
    t = 3;

    // h=2, LEN=5, payload 1,0,1,1,0 in arrival order
    sched(t, 2, 5, 256'b01101, K_CLEAN, 0, t);
    t += 2;
    sched(t, 0, 0, rand_pay(), K_CLEAN, 0, t);
    t += 3;
    // back-to-back at the minimum gap
    sched(t, 1, 3, rand_pay(), K_CLEAN, 0, t);
    sched(t, 3, 2, rand_pay(), K_CLEAN, 0, t);
    t += 1;
    sched(t, $urandom_range(0, 3), 8, rand_pay(), K_TRUNC, 12, t);
    t += 2;
    sched(t, 2, 4, rand_pay(), K_LONG, 3, t);
    sched(t, 1, $urandom_range(1, 12), rand_pay(), K_CLEAN, 0, t);
    t += 2;
    sched(t, 3, 20, rand_pay(), K_RST, 15, t);
    sched(t, 0, 6, rand_pay(), K_CLEAN, 0, t);
    t += 1;
    // truncation inside the header, then maximal LEN
    sched(t, 1, 9, rand_pay(), K_TRUNC, 4, t);
    t += 1;
    sched(t, $urandom_range(0, 3), 255, rand_pay(), K_CLEAN, 0, t);
    for (int i = 0; i < 12; i++) begin
      t += $urandom_range(0, 3);
      h   = $urandom_range(0, 3);
      len = $urandom_range(0, 40);
      sched(t, h, len, rand_pay(), (i == 6) ? K_LONG : K_CLEAN, (i == 6) ? 5 : 0, t);
    end
    endc = t + 4;

    rst      = st_r[0];
    in_valid = st_v[0];
    in_bit   = st_b[0];
    for (int c = 1; c <= endc; c++) begin
      @(posedge clk);
      #1;
      chk("out_valid", c, out_valid, ex_ov[c]);
      chk("sel",       c, sel,       ex_ov[c]);
      chk("out_bit",   c, out_bit,   ex_ob[c]);
      chk("busy",      c, NH'(busy), NH'(ex_busy[c]));
      chk("err",       c, NH'(err),  NH'(ex_err[c]));
      rst      = st_r[c];
      in_valid = st_v[c];
      in_bit   = st_b[c];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
